// File: rtl/vga_layer_arb_pkg.sv
// Shared VGA layer-compositing parameters, state encoding and helpers.
// Geometry and colour width match the values used with vga_sync.
package vga_layer_arb_pkg;

  localparam int COLOR_W    = 10;
  localparam int RGB_W      = 3 * COLOR_W;
  localparam int H_ACTIVE_D = 640;
  localparam int V_ACTIVE_D = 480;
  localparam int NLAYER_D   = 4;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } arb_state_e;

  // Unsigned 10-bit visible-area test; the edge values themselves are outside.
  function automatic logic in_active(input logic [9:0] px, input logic [9:0] py,
                                     input logic [9:0] h,  input logic [9:0] v);
    return (px < h) && (py < v);
  endfunction

endpackage

// File: rtl/vga_layer_arb_if.sv
// Pixel/layer bus between the sync generator + layer sources and the compositor.
interface vga_layer_arb_if #(
  parameter int NLAYER = 4
);
  logic [9:0]           iPX;
  logic [9:0]           iPY;
  logic [NLAYER-1:0]    iReq;
  logic [30*NLAYER-1:0] iLayer_RGB;
  logic [NLAYER-1:0]    iLayer_Key;
  logic [9:0]           oRed;
  logic [9:0]           oGreen;
  logic [9:0]           oBlue;
  logic [NLAYER-1:0]    oGnt;
  logic                 oFrame_Start;
  logic [7:0]           oFrame_Cnt;

  modport master (
    output iPX, iPY, iReq, iLayer_RGB, iLayer_Key,
    input  oRed, oGreen, oBlue, oGnt, oFrame_Start, oFrame_Cnt
  );

  modport slave (
    input  iPX, iPY, iReq, iLayer_RGB, iLayer_Key,
    output oRed, oGreen, oBlue, oGnt, oFrame_Start, oFrame_Cnt
  );
endinterface

// File: rtl/vga_layer_pick.sv
// Combinational priority pick: lowest-index granted, opaque layer wins.
module vga_layer_pick import vga_layer_arb_pkg::*; #(
  parameter int NLAYER = NLAYER_D
) (
  input  logic [NLAYER-1:0]            grant,
  input  logic [NLAYER-1:0]            key,
  input  logic [NLAYER-1:0][RGB_W-1:0] colours,
  output logic                         hit,
  output logic [RGB_W-1:0]             colour
);
  logic [NLAYER-1:0] qual;

  genvar k;
  generate
    for (k = 0; k < NLAYER; k++) begin : g_qual
      assign qual[k] = grant[k] & ~key[k];
    end
  endgenerate

  // Scan high to low so the lowest qualifying index is the last write.
  always_comb begin
    hit    = 1'b0;
    colour = '0;
    for (int i = NLAYER - 1; i >= 0; i--) begin
      if (qual[i]) begin
        hit    = 1'b1;
        colour = colours[i];
      end
    end
  end
endmodule

// File: rtl/vga_layer_arb.sv
// Frame-synchronous layer arbiter/compositor: grants latch at each frame wrap,
// colour is registered one cycle after the pixel coordinates.
module vga_layer_arb import vga_layer_arb_pkg::*; #(
  parameter int               NLAYER   = NLAYER_D,
  parameter int               H_ACTIVE = H_ACTIVE_D,
  parameter int               V_ACTIVE = V_ACTIVE_D,
  parameter logic [RGB_W-1:0] BG_RGB   = '0
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  vga_layer_arb_if.slave bus
);
  arb_state_e               state;
  logic [9:0]               py_prev;
  logic [NLAYER-1:0]        gnt;
  logic                     frame_start;
  logic [7:0]               frame_cnt;
  logic [RGB_W-1:0]         rgb_q;
  logic                     boundary;
  logic                     active;
  logic                     hit;
  logic [RGB_W-1:0]         pick_rgb;
  logic [NLAYER-1:0][RGB_W-1:0] layer_rgb;

  assign layer_rgb = bus.iLayer_RGB;
  assign boundary  = (bus.iPY == 10'd0) && (py_prev != 10'd0);
  assign active    = in_active(bus.iPX, bus.iPY, 10'(H_ACTIVE), 10'(V_ACTIVE));

  vga_layer_pick #(.NLAYER(NLAYER)) u_pick (
    .grant   (gnt),
    .key     (bus.iLayer_Key),
    .colours (layer_rgb),
    .hit     (hit),
    .colour  (pick_rgb)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= WAIT_SYNC;
      py_prev     <= '0;
      gnt         <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      rgb_q       <= '0;
    end else begin
      py_prev     <= bus.iPY;
      frame_start <= boundary;
      if (boundary) begin
        state     <= RUN;
        gnt       <= bus.iReq;
        frame_cnt <= frame_cnt + 8'd1;
      end
      // Colour uses the grant/state in force before this edge's load.
      if (state == RUN && active)
        rgb_q <= hit ? pick_rgb : BG_RGB;
      else
        rgb_q <= '0;
    end
  end

  assign bus.oRed         = rgb_q[29:20];
  assign bus.oGreen       = rgb_q[19:10];
  assign bus.oBlue        = rgb_q[9:0];
  assign bus.oGnt         = gnt;
  assign bus.oFrame_Start = frame_start;
  assign bus.oFrame_Cnt   = frame_cnt;
endmodule

// File: tb/tb_vga_layer_arb.sv
// Directed bench for vga_layer_arb with a frame-level reference model and
// a per-cycle compare process.
module tb_vga_layer_arb;
  localparam int          NL  = 4;
  localparam logic [29:0] BG  = {10'h155, 10'h2AA, 10'h0F0};
  localparam logic [29:0] RED = {10'h3FF, 10'h000, 10'h000};
  localparam logic [29:0] GRN = {10'h000, 10'h3FF, 10'h000};

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   fs_pulses = 0;
  bit   cmp_en = 1'b0;

  vga_layer_arb_if #(.NLAYER(NL)) bus ();

  vga_layer_arb #(.NLAYER(NL), .H_ACTIVE(640), .V_ACTIVE(480), .BG_RGB(BG)) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .bus    (bus)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame wraps are when Y returns to 0 from a nonzero Y.
  bit          m_run = 0;
  logic [3:0]  m_gnt = '0;
  logic [9:0]  m_prev = '0;
  int          m_cnt = 0;
  bit          m_fs = 0;
  logic [29:0] m_col = '0;

  function automatic logic [29:0] exp_col(input bit run, input logic [3:0] g,
      input int px, input int py, input logic [119:0] rgb, input logic [3:0] key);
    if (!run || px >= 640 || py >= 480) return 30'h0;
    for (int k = 0; k < NL; k++)
      if (g[k] && !key[k]) return rgb[30*k +: 30];
    return BG;
  endfunction

  always @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      m_run <= 0; m_gnt <= '0; m_prev <= '0; m_cnt <= 0; m_fs <= 0; m_col <= '0;
    end else begin
      m_col  <= exp_col(m_run, m_gnt, int'(bus.iPX), int'(bus.iPY), bus.iLayer_RGB, bus.iLayer_Key);
      m_prev <= bus.iPY;
      m_fs   <= (bus.iPY == 0) && (m_prev != 0);
      if ((bus.iPY == 0) && (m_prev != 0)) begin
        m_run <= 1;
        m_gnt <= bus.iReq;
        m_cnt <= (m_cnt + 1) % 256;
      end
    end
  end

  always @(negedge iCLK) begin
    if (cmp_en) begin
      chk("cyc_rgb", 32'({bus.oRed, bus.oGreen, bus.oBlue}), 32'(m_col));
      chk("cyc_gnt", 32'(bus.oGnt), 32'(m_gnt));
      chk("cyc_fs",  32'(bus.oFrame_Start), 32'(m_fs));
      chk("cyc_cnt", 32'(bus.oFrame_Cnt), 32'(m_cnt));
      if (bus.oFrame_Start) fs_pulses++;
    end
  end

  function automatic logic [31:0] rgb_out();
    return 32'({bus.oRed, bus.oGreen, bus.oBlue});
  endfunction

  task automatic cycle(input int px, input int py);
    @(negedge iCLK);
    bus.iPX = 10'(px);
    bus.iPY = 10'(py);
    @(posedge iCLK);
    #1;
  endtask

  task automatic lines(input int from, input int to, input int px);
    for (int y = from; y <= to; y++) cycle(px, y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bus.iPX = '0; bus.iPY = '0; bus.iReq = '0;
    bus.iLayer_RGB = '0; bus.iLayer_Key = '0;
    repeat (3) @(posedge iCLK);
    #1;
    cmp_en = 1'b1;
    chk("rst_rgb", rgb_out(), 32'h0);
    chk("rst_gnt", 32'(bus.oGnt), 32'h0);
    chk("rst_fs",  32'(bus.oFrame_Start), 32'h0);
    chk("rst_cnt", 32'(bus.oFrame_Cnt), 32'h0);

    // Single red layer; nothing shown until the first wrap.
    bus.iReq = 4'b0001;
    bus.iLayer_RGB = {90'h0, RED};
    @(negedge iCLK); iRST_N = 1'b1;
    lines(1, 524, 10);
    chk("wait_sync_rgb", rgb_out(), 32'h0);
    cycle(10, 0);
    chk("wrap1_gnt", 32'(bus.oGnt), 32'h1);
    chk("wrap1_fs",  32'(bus.oFrame_Start), 32'h1);
    chk("wrap1_cnt", 32'(bus.oFrame_Cnt), 32'h1);
    chk("wrap1_rgb", rgb_out(), 32'h0);
    cycle(10, 1);
    chk("red_rgb", rgb_out(), 32'(RED));
    chk("red_fs",  32'(bus.oFrame_Start), 32'h0);

    // Transparency fall-through and background.
    bus.iReq = 4'b0011;
    lines(2, 524, 10);
    cycle(10, 0);
    chk("gnt_0011", 32'(bus.oGnt), 32'h3);
    bus.iLayer_RGB = {60'h0, GRN, RED};
    bus.iLayer_Key = 4'b0001;
    cycle(5, 5);
    chk("green_rgb", rgb_out(), 32'(GRN));
    bus.iLayer_Key = 4'b0011;
    cycle(5, 6);
    chk("bg_rgb", rgb_out(), 32'(BG));

    // Active-area edges.
    bus.iLayer_Key = 4'b0001;
    cycle(640, 100);
    chk("px640_rgb", rgb_out(), 32'h0);
    cycle(639, 479);
    chk("px639_py479_rgb", rgb_out(), 32'(GRN));
    cycle(639, 480);
    chk("py480_rgb", rgb_out(), 32'h0);
    lines(481, 524, 0);

    // Mid-frame request change waits for the next wrap.
    bus.iReq = 4'b0001;
    cycle(0, 0);
    lines(1, 199, 0);
    bus.iReq = 4'b0010;
    lines(200, 524, 0);
    chk("midframe_gnt_hold", 32'(bus.oGnt), 32'h1);
    p0 = fs_pulses;
    cycle(0, 0);
    chk("wrap_gnt_0010", 32'(bus.oGnt), 32'h2);
    lines(1, 5, 0);
    chk("single_fs_pulse", 32'(fs_pulses - p0), 32'h1);

    // One-frame show, then a non-boundary pulse is ignored.
    bus.iReq = 4'b0100;
    lines(6, 524, 0);
    cycle(0, 0);
    chk("gnt_0100", 32'(bus.oGnt), 32'h4);
    bus.iReq = 4'b0000;
    lines(1, 99, 0);
    bus.iReq = 4'b1000;
    cycle(0, 100);
    bus.iReq = 4'b0000;
    lines(101, 524, 0);
    cycle(0, 0);
    chk("pulse_ignored_gnt", 32'(bus.oGnt), 32'h0);
    cycle(3, 3);
    chk("no_gnt_bg", rgb_out(), 32'(BG));

    // Asynchronous reset mid-frame.
    bus.iReq = 4'b0001;
    bus.iLayer_Key = 4'b0000;
    lines(4, 524, 10);
    cycle(10, 0);
    lines(1, 299, 10);
    cycle(10, 300);
    chk("pre_rst_rgb", rgb_out(), 32'(RED));
    #1 iRST_N = 1'b0;
    #1;
    chk("async_rst_rgb", rgb_out(), 32'h0);
    chk("async_rst_gnt", 32'(bus.oGnt), 32'h0);
    chk("async_rst_cnt", 32'(bus.oFrame_Cnt), 32'h0);
    @(negedge iCLK); iRST_N = 1'b1;
    p0 = fs_pulses;
    lines(301, 524, 10);
    chk("post_rst_rgb", rgb_out(), 32'h0);
    chk("post_rst_cnt", 32'(bus.oFrame_Cnt), 32'h0);
    cycle(10, 0);
    chk("post_rst_wrap_cnt", 32'(bus.oFrame_Cnt), 32'h1);
    chk("post_rst_wrap_gnt", 32'(bus.oGnt), 32'h1);
    cycle(10, 1);
    chk("post_rst_red", rgb_out(), 32'(RED));

    // 256 frames since reset: counter wraps back to 0.
    for (int f = 0; f < 255; f++) begin
      lines(1, 9, 10);
      cycle(10, 0);
    end
    lines(1, 2, 10);
    chk("cnt_wrap", 32'(bus.oFrame_Cnt), 32'h0);
    chk("fs_256", 32'(fs_pulses - p0), 32'd256);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
